// File: rtl/btn_frame_conditioner_if.sv
// Button/frame bundle between the raw-input side and the conditioner.
// The master drives raw buttons and the frame tick; the slave returns requests.
interface btn_frame_conditioner_if;
  logic i_Btn_Left_Raw;
  logic i_Btn_Right_Raw;
  logic i_fTick;
  logic o_Btn_Left;
  logic o_Btn_Right;
  logic o_Stable_Left;
  logic o_Stable_Right;

  modport master (
    output i_Btn_Left_Raw,
    output i_Btn_Right_Raw,
    output i_fTick,
    input  o_Btn_Left,
    input  o_Btn_Right,
    input  o_Stable_Left,
    input  o_Stable_Right
  );

  modport slave (
    input  i_Btn_Left_Raw,
    input  i_Btn_Right_Raw,
    input  i_fTick,
    output o_Btn_Left,
    output o_Btn_Right,
    output o_Stable_Left,
    output o_Stable_Right
  );
endinterface

// File: rtl/btn_frame_conditioner.sv
// Sync, debounce and frame-latch for left/right buttons.
// BTN_ACTIVE_LOW_EN selects active-low raw buttons.
module btn_frame_conditioner #(
  parameter int DEBOUNCE_CYCLES = 750000,
  parameter int CNT_W           = 20
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  btn_frame_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_ACTIVE_LOW_EN
  localparam logic [1:0] IDLE_LVL = 2'b11;
`else
  localparam logic [1:0] IDLE_LVL = 2'b00;
`endif

  // index 0 = left, 1 = right
  logic [1:0] raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] s;
  logic [1:0] stab_q;
  logic [1:0] stab_d;
  logic [1:0] sticky_q;
  logic [1:0] sticky_d;
  logic [1:0] btn_q;
  logic [1:0] btn_d;
  logic [1:0] req;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign raw = {bus.i_Btn_Right_Raw, bus.i_Btn_Left_Raw};

  // Flops carry the electrical level and reset to the idle level,
  // so the pressed view below is 0 right after reset in both builds.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ IDLE_LVL;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]  = cnt_q[i];
      stab_d[i] = stab_q[i];
      if (s[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        stab_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      stab_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      stab_q   <= stab_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Frame request folds in the live level so a press at the tick counts.
  assign req = sticky_q | stab_q;

  always_comb begin
    sticky_d = sticky_q | stab_q;
    btn_d    = btn_q;
    if (bus.i_fTick) begin
      sticky_d = '0;
      btn_d    = (&req) ? 2'b00 : req;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sticky_q <= '0;
      btn_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      btn_q    <= btn_d;
    end
  end

  assign bus.o_Btn_Left     = btn_q[0];
  assign bus.o_Btn_Right    = btn_q[1];
  assign bus.o_Stable_Left  = stab_q[0];
  assign bus.o_Stable_Right = stab_q[1];

endmodule

// File: tb/tb_btn_frame_conditioner.sv
// Directed bench for btn_frame_conditioner, DEBOUNCE_CYCLES = 4.
// Press levels follow BTN_ACTIVE_LOW_EN so either build can be run.
module tb_btn_frame_conditioner;

`ifdef BTN_ACTIVE_LOW_EN
  localparam logic PR = 1'b0;
`else
  localparam logic PR = 1'b1;
`endif

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  btn_frame_conditioner_if bus ();

  btn_frame_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic press(input logic l, input logic r);
    bus.i_Btn_Left_Raw  = l ? PR : ~PR;
    bus.i_Btn_Right_Raw = r ? PR : ~PR;
  endtask

  task automatic tick(input int n);
    bus.i_fTick = 1'b1;
    step(n);
    bus.i_fTick = 1'b0;
  endtask

  initial begin
    bus.i_fTick = 1'b0;
    press(1'b1, 1'b1);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    chk("rst_btnL", bus.o_Btn_Left, 1'b0);
    chk("rst_btnR", bus.o_Btn_Right, 1'b0);
    chk("rst_stabL", bus.o_Stable_Left, 1'b0);
    chk("rst_stabR", bus.o_Stable_Right, 1'b0);
    step(1);
    i_Rst = 1'b0;
    step(5);
    chk("rel5_stabL", bus.o_Stable_Left, 1'b0);
    step(1);
    chk("rel6_stabL", bus.o_Stable_Left, 1'b1);
    chk("rel6_stabR", bus.o_Stable_Right, 1'b1);
    tick(1);
    chk("both0_btnL", bus.o_Btn_Left, 1'b0);
    chk("both0_btnR", bus.o_Btn_Right, 1'b0);

    press(1'b0, 1'b0);
    step(6);
    chk("idle_stabL", bus.o_Stable_Left, 1'b0);
    tick(1);
    step(1);
    tick(1);
    chk("idle_btnL", bus.o_Btn_Left, 1'b0);
    chk("idle_btnR", bus.o_Btn_Right, 1'b0);

    for (int i = 0; i < 4; i++) begin
      press(i % 2 == 0, 1'b0);
      step(1);
      chk("bounce_stabL", bus.o_Stable_Left, 1'b0);
    end
    press(1'b1, 1'b0);
    step(5);
    chk("bounce5_stabL", bus.o_Stable_Left, 1'b0);
    step(1);
    chk("bounce6_stabL", bus.o_Stable_Left, 1'b1);

    press(1'b0, 1'b0);
    step(6);
    chk("short_relL", bus.o_Stable_Left, 1'b0);
    chk("short_pre_btnL", bus.o_Btn_Left, 1'b0);
    tick(1);
    chk("short_btnL", bus.o_Btn_Left, 1'b1);
    chk("short_btnR", bus.o_Btn_Right, 1'b0);
    step(3);
    chk("short_hold", bus.o_Btn_Left, 1'b1);
    tick(1);
    chk("short_next", bus.o_Btn_Left, 1'b0);

    press(1'b1, 1'b1);
    step(6);
    tick(1);
    chk("lr_btnL", bus.o_Btn_Left, 1'b0);
    chk("lr_btnR", bus.o_Btn_Right, 1'b0);
    press(1'b0, 1'b1);
    step(6);
    chk("lr_stabL", bus.o_Stable_Left, 1'b0);
    tick(1);
    chk("lr_mid_btnR", bus.o_Btn_Right, 1'b0);
    step(2);
    tick(1);
    chk("r_btnL", bus.o_Btn_Left, 1'b0);
    chk("r_btnR", bus.o_Btn_Right, 1'b1);
    tick(2);
    chk("mtick_btnR", bus.o_Btn_Right, 1'b1);
    chk("mtick_btnL", bus.o_Btn_Left, 1'b0);

    press(1'b0, 1'b0);
    step(6);
    tick(1);
    press(1'b0, 1'b1);
    step(6);
    chk("mid_stabR", bus.o_Stable_Right, 1'b1);
    press(1'b0, 1'b0);
    step(6);
    chk("mid_relR", bus.o_Stable_Right, 1'b0);
    i_Rst = 1'b1;
    step(1);
    i_Rst = 1'b0;
    chk("mid_rst_btnR", bus.o_Btn_Right, 1'b0);
    tick(1);
    chk("mid_tick_btnR", bus.o_Btn_Right, 1'b0);

    press(1'b1, 1'b0);
    step(6);
    i_Rst = 1'b1;
    bus.i_fTick = 1'b1;
    step(1);
    i_Rst = 1'b0;
    bus.i_fTick = 1'b0;
    chk("rst_win_btnL", bus.o_Btn_Left, 1'b0);
    chk("rst_win_stabL", bus.o_Stable_Left, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
